// File: rtl/nonce_scheduler.sv
// Nonce-range scheduler for an array of double-SHA-256 cores. It hands out one nonce per cycle
// to the lowest free core, and stops on the first hit, on a stop request or when the range runs out.
module nonce_scheduler #(
  parameter int NUM_CORES = 2,
  parameter int NONCE_W   = 32
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NONCE_W-1:0]           nonce_start,
  input  logic [NONCE_W-1:0]           nonce_end,
  output logic [NUM_CORES-1:0]         core_hash_enable,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_finished,
  input  logic [NUM_CORES-1:0]         core_hit,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic                         exhausted,
  output logic [31:0]                  hashes_done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                 state;
  logic [NONCE_W-1:0]     next_nonce;
  logic [NONCE_W-1:0]     end_nonce;
  logic                   range_done;
  logic [NUM_CORES-1:0]   core_busy;
  logic [NONCE_W-1:0]     nonce_q [NUM_CORES];

  logic [NUM_CORES-1:0]   fin_mask;
  logic [NUM_CORES-1:0]   hit_mask;
  logic [NUM_CORES-1:0]   launch_mask;
  logic [NUM_CORES-1:0]   busy_after;
  logic                   hit_any;
  logic                   free_any;
  logic                   launch_go;
  logic [IDX_W-1:0]       hit_idx;
  logic [IDX_W-1:0]       free_idx;

  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_CORES-1:0] v);
    first_set = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDX_W'(i);
    end
  endfunction

  function automatic logic [31:0] count_ones(input logic [NUM_CORES-1:0] v);
    count_ones = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      count_ones = count_ones + {31'b0, v[i]};
    end
  endfunction

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
    assign core_nonce[g*NONCE_W +: NONCE_W] = nonce_q[g];
  end

  // Only completions from cores we actually launched count; a launch is held off on a hit or stop.
  always_comb begin
    fin_mask    = core_finished & core_busy;
    hit_mask    = fin_mask & core_hit;
    hit_any     = |hit_mask;
    hit_idx     = first_set(hit_mask);
    free_any    = |(~core_busy);
    free_idx    = first_set(~core_busy);
    launch_go   = (state == DISPATCH) && !range_done && free_any && !hit_any && !stop;
    launch_mask = launch_go ? (NUM_CORES'(1) << free_idx) : '0;
    busy_after  = (core_busy & ~fin_mask) | launch_mask;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      next_nonce       <= '0;
      end_nonce        <= '0;
      range_done       <= 1'b0;
      core_busy        <= '0;
      core_hash_enable <= '0;
      for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      found            <= 1'b0;
      found_nonce      <= '0;
      exhausted        <= 1'b0;
      hashes_done      <= '0;
    end else begin
      core_hash_enable <= launch_mask;
      core_busy        <= busy_after;
      hashes_done      <= hashes_done + count_ones(fin_mask);
      done             <= 1'b0;

      // Stopping on equality with the end nonce keeps an all-ones end from wrapping to zero.
      if (launch_go) begin
        nonce_q[free_idx] <= next_nonce;
        if (next_nonce == end_nonce) range_done <= 1'b1;
        else                         next_nonce <= next_nonce + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            end_nonce   <= nonce_end;
            found       <= 1'b0;
            found_nonce <= '0;
            exhausted   <= 1'b0;
            hashes_done <= '0;
            if (nonce_start > nonce_end) begin
              exhausted <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              next_nonce <= nonce_start;
              range_done <= 1'b0;
              busy       <= 1'b1;
              state      <= DISPATCH;
            end
          end
        end
        DISPATCH: begin
          if (hit_any) begin
            found       <= 1'b1;
            found_nonce <= nonce_q[hit_idx];
            state       <= DRAIN;
          end else if (stop) begin
            state <= DRAIN;
          end else if (range_done && (busy_after == '0)) begin
            exhausted <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DRAIN: begin
          if (busy_after == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
